// File: rtl/instr_fifo_pkg.sv
// Shared types and defaults for the PIO instruction FIFO bridge.
package instr_fifo_pkg;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_ALMOST_LVL = 14;

    // payload lands in bits [63:32], word_a in bits [31:0]
    typedef struct packed {
        logic [31:0] payload;
        logic [31:0] word_a;
    } instr_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } strobe_state_e;

endpackage

// File: rtl/instr_fifo_bridge_if.sv
// Software-facing write side and graphics-facing valid/ready side of the bridge.
interface instr_fifo_bridge_if #(
    parameter int AW = 4
);
    import instr_fifo_pkg::*;

    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        wrreg;
    logic        wrfull;
    logic        almost_full;
    logic        overflow;
    logic        ovf_clr;
    instr_t      instr_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [AW:0] level;

    modport master (
        output data_a, data_b, wrreg, ovf_clr, instr_ready,
        input  wrfull, almost_full, overflow, instr_data, instr_valid, level
    );

    modport slave (
        input  data_a, data_b, wrreg, ovf_clr, instr_ready,
        output wrfull, almost_full, overflow, instr_data, instr_valid, level
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 64 register array: synchronous write, asynchronous read, contents never reset.
module sync_fifo_mem
    import instr_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  instr_t        wdata,
    input  logic [AW-1:0] raddr,
    output instr_t        rdata
);

    instr_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fifo_bridge.sv
// Captures software instructions on a wrreg rising edge into a FIFO and hands them out via valid/ready.
// Optional statistics counters are built when INSTR_FIFO_STATS_EN is defined.
module instr_fifo_bridge
    import instr_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AW         = $clog2(DEPTH),
    parameter int ALMOST_LVL = DEFAULT_ALMOST_LVL
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    instr_fifo_bridge_if.slave  bus
`ifdef INSTR_FIFO_STATS_EN
    ,
    output logic [31:0]         stat_accepted,
    output logic [15:0]         stat_dropped
`endif
);

    localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST_CNT = (AW+1)'(ALMOST_LVL);

    strobe_state_e strobe_q, strobe_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push_req, push, pop;
    instr_t        wr_entry;

    // HELD means wrreg was high last cycle, so only the 0->1 transition requests a push
    always_comb begin
        strobe_d = strobe_q;
        push_req = 1'b0;
        unique case (strobe_q)
            ST_IDLE: begin
                if (bus.wrreg) begin
                    strobe_d = ST_HELD;
                    push_req = 1'b1;
                end
            end
            ST_HELD: begin
                if (!bus.wrreg) begin
                    strobe_d = ST_IDLE;
                end
            end
            default: strobe_d = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        pop        = (count_q != '0) & bus.instr_ready;
        push       = push_req & ((count_q < FULL_LVL) | pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (push_req && !push) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            strobe_q   <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            strobe_q   <= strobe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_entry = '{payload: bus.data_b, word_a: bus.data_a};

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (bus.instr_data)
    );

    assign bus.instr_valid = (count_q != '0);
    assign bus.wrfull      = (count_q == FULL_LVL);
    assign bus.almost_full = (count_q >= ALMOST_CNT);
    assign bus.overflow    = overflow_q;
    assign bus.level       = count_q;

`ifdef INSTR_FIFO_STATS_EN
    logic [31:0] stat_accepted_q, stat_accepted_d;
    logic [15:0] stat_dropped_q, stat_dropped_d;

    always_comb begin
        stat_accepted_d = push ? stat_accepted_q + 1'b1 : stat_accepted_q;
        stat_dropped_d  = (push_req && !push) ? stat_dropped_q + 1'b1 : stat_dropped_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stat_accepted_q <= '0;
            stat_dropped_q  <= '0;
        end else begin
            stat_accepted_q <= stat_accepted_d;
            stat_dropped_q  <= stat_dropped_d;
        end
    end

    assign stat_accepted = stat_accepted_q;
    assign stat_dropped  = stat_dropped_q;
`endif

endmodule

// File: tb/tb_instr_fifo_bridge.sv
// Directed plus randomized bench for instr_fifo_bridge against a queue-based model of the FIFO rules.
module tb_instr_fifo_bridge;

    localparam int DEPTH      = 16;
    localparam int AW         = 4;
    localparam int ALMOST_LVL = 14;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b1;

    instr_fifo_bridge_if #(.AW(AW)) bus ();

`ifdef INSTR_FIFO_STATS_EN
    logic [31:0] stat_accepted;
    logic [15:0] stat_dropped;
`endif

    instr_fifo_bridge #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .ALMOST_LVL (ALMOST_LVL)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus)
`ifdef INSTR_FIFO_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_dropped  (stat_dropped)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] model_q[$];
    logic        model_ovf = 1'b0;
    logic        prev_wrreg = 1'b0;
    int unsigned model_acc = 0;
    int unsigned model_drop = 0;
    int unsigned next_id = 0;
    logic [63:0] exp_head;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance the model by the same cycle once the edge has passed
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] b,
                                 input logic rdy, input logic clr);
        logic pop_m, req_m, acc_m;
        bus.wrreg       = wr;
        bus.data_a      = a;
        bus.data_b      = b;
        bus.instr_ready = rdy;
        bus.ovf_clr     = clr;
        pop_m = (model_q.size() != 0) && rdy;
        req_m = wr && !prev_wrreg;
        acc_m = req_m && ((model_q.size() < DEPTH) || pop_m);
        @(posedge clk_clk);
        #1;
        if (pop_m) void'(model_q.pop_front());
        if (acc_m) begin
            model_q.push_back({b, a});
            model_acc++;
        end
        if (req_m && !acc_m) begin
            model_ovf = 1'b1;
            model_drop++;
        end else if (clr) begin
            model_ovf = 1'b0;
        end
        prev_wrreg = wr;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_level"}, 64'(bus.level), 64'(model_q.size()));
        checkOutput({tag, "_valid"}, 64'(bus.instr_valid), 64'(model_q.size() != 0));
        checkOutput({tag, "_wrfull"}, 64'(bus.wrfull), 64'(model_q.size() == DEPTH));
        checkOutput({tag, "_almost"}, 64'(bus.almost_full), 64'(model_q.size() >= ALMOST_LVL));
        checkOutput({tag, "_ovf"}, 64'(bus.overflow), 64'(model_ovf));
        if (model_q.size() != 0) checkOutput({tag, "_data"}, 64'(bus.instr_data), model_q[0]);
`ifdef INSTR_FIFO_STATS_EN
        checkOutput({tag, "_stat_acc"}, 64'(stat_accepted), 64'(32'(model_acc)));
        checkOutput({tag, "_stat_drop"}, 64'(stat_dropped), 64'(16'(model_drop)));
`endif
    endtask

    task automatic strobeStep(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic rdy1, input logic rdy2);
        applyStimulus(1'b1, a, b, rdy1, 1'b0);
        checkState({tag, "_hi"});
        applyStimulus(1'b0, a, b, rdy2, 1'b0);
        checkState({tag, "_lo"});
    endtask

    // Every model pop must present the next sequential id at the head
    task automatic orderStep(input logic wr, input logic [31:0] a, input logic rdy);
        if (model_q.size() != 0 && rdy) begin
            checkOutput("order_head", 64'(bus.instr_data.word_a), 64'(next_id));
            next_id++;
        end
        applyStimulus(wr, a, $urandom, rdy, 1'b0);
        checkState("order");
    endtask

    initial begin
        bus.wrreg       = 1'b0;
        bus.data_a      = '0;
        bus.data_b      = '0;
        bus.instr_ready = 1'b0;
        bus.ovf_clr     = 1'b0;

        #1 reset_reset_n = 1'b0;
        #2;
        checkState("reset");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;

        // One long wrreg level yields exactly one entry, visible the next cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 1'b0, 1'b0);
            checkState("single");
            if (i == 0) checkOutput("single_latency_valid", 64'(bus.instr_valid), 64'd1);
        end
        checkOutput("single_level", 64'(bus.level), 64'd1);
        checkOutput("single_data", 64'(bus.instr_data), 64'hDEAD_BEEF_0000_0012);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkState("single_release");
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkState("single_drain");
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkState("empty_ready");

        // Fill to full, then overflow and clear it
        for (int i = 0; i < 16; i++) begin
            strobeStep("fill", 32'(i), $urandom, 1'b0, 1'b0);
            if (i == 12) checkOutput("almost_at13", 64'(bus.almost_full), 64'd0);
            if (i == 13) checkOutput("almost_at14", 64'(bus.almost_full), 64'd1);
        end
        checkOutput("fill_wrfull", 64'(bus.wrfull), 64'd1);
        checkOutput("fill_level", 64'(bus.level), 64'd16);
        strobeStep("ovf", 32'd16, $urandom, 1'b0, 1'b0);
        checkOutput("ovf_set", 64'(bus.overflow), 64'd1);
        checkOutput("ovf_level", 64'(bus.level), 64'd16);
`ifdef INSTR_FIFO_STATS_EN
        checkOutput("ovf_stat_dropped", 64'(stat_dropped), 64'd1);
`endif
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkState("ovf_clr");
        checkOutput("ovf_cleared", 64'(bus.overflow), 64'd0);

        // Push while full with a simultaneous pop
        checkOutput("full_head", 64'(bus.instr_data.word_a), 64'd0);
        strobeStep("fullpp", 32'h0000_00AA, $urandom, 1'b1, 1'b0);
        checkOutput("fullpp_level", 64'(bus.level), 64'd16);
        checkOutput("fullpp_ovf", 64'(bus.overflow), 64'd0);
        checkOutput("fullpp_head", 64'(bus.instr_data.word_a), 64'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) checkOutput("fullpp_tail", 64'(bus.instr_data.word_a), 64'h0000_00AA);
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            checkState("drain1");
        end

        // Ordering across pointer wrap with random back-pressure
        for (int i = 0; i < 40; i++) begin
            orderStep(1'b1, 32'(i), 1'($urandom_range(0, 3) != 0));
            orderStep(1'b0, 32'(i), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20; i++) begin
            orderStep(1'b0, '0, 1'b1);
        end
        checkOutput("order_empty", 64'(bus.level), 64'd0);

        // Head must stay stable under back-pressure while new entries queue up
        strobeStep("bp_first", 32'h0000_0100, $urandom, 1'b0, 1'b0);
        exp_head = model_q[0];
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i == 2 || i == 8 || i == 14), 32'(i), $urandom, 1'b0, 1'b0);
            checkState("bp");
            checkOutput("bp_stable", 64'(bus.instr_data), exp_head);
        end
        checkOutput("bp_level", 64'(bus.level), 64'd4);

        // Asynchronous reset mid-traffic with five entries buffered
        strobeStep("pre_reset", 32'h0000_0200, $urandom, 1'b0, 1'b0);
        checkOutput("pre_reset_level", 64'(bus.level), 64'd5);
        #2 reset_reset_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf  = 1'b0;
        prev_wrreg = 1'b0;
        model_acc  = 0;
        model_drop = 0;
        checkState("async_reset");
        checkOutput("async_reset_valid", 64'(bus.instr_valid), 64'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
        strobeStep("post_reset", 32'h0000_0300, $urandom, 1'b0, 1'b0);
        checkOutput("post_reset_level", 64'(bus.level), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fifo_bridge.md
Name: instr_fifo_bridge

Overview:
- Downstream stage of the HPS/Nios PIO subsystem: captures 64-bit instructions that software places on data_a/data_b and commits with a wrreg pulse.
- Buffers them in a FIFO and presents them to the graphics processor with a valid/ready handshake.
- Drives wrfull back to the PIO input so software polls before writing.
- Handles edge detection of the software strobe, overflow tracking and simultaneous push/pop.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, pointer width; equals log2(DEPTH).
- ALMOST_LVL, 14, occupancy at or above which almost_full asserts.

Ports:
- clk_clk  in  1  system clock, shared with the PIO subsystem.
- reset_reset_n  in  1  asynchronous active-low reset.
- data_a  in  32  instruction word A; opcode/register field, stored as bits [31:0].
- data_b  in  32  instruction word B; payload, stored as bits [63:32].
- wrreg  in  1  software write strobe, level-driven as 0→1→0.
- wrfull  out  1  FIFO full; fed to the PIO wrfull input.
- almost_full  out  1  occupancy ≥ ALMOST_LVL.
- overflow  out  1  sticky: a strobe arrived while the FIFO could not accept it.
- ovf_clr  in  1  single-cycle clear of overflow.
- instr_data  out  64  head-of-FIFO instruction {data_b, data_a}.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  consumer accepts the head entry.
- level  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, while reset_reset_n = 0):
  - Clears wrreg_q, pointers, count, overflow and the stats counters.
  - wrfull = 0, almost_full = 0, instr_valid = 0, level = 0; instr_data is don't-care.
  - Reset mid-operation discards all buffered entries; memory contents are not cleared.
- Strobe detection:
  - wrreg_q holds the previous wrreg; push_req = wrreg & ~wrreg_q.
  - Holding wrreg high produces exactly one request; a 1-cycle pulse produces one request.
  - Strobe FSM states: IDLE (wrreg_q = 0) and HELD (wrreg_q = 1).
  - IDLE→HELD on wrreg = 1, and push_req fires on that edge; HELD→IDLE on wrreg = 0.
- Pop: pop = instr_valid & instr_ready.
- Push acceptance: push = push_req & (count < DEPTH | pop).
  - When full with a simultaneous pop, the push is accepted, count is unchanged and the pointers advance.
- Overflow:
  - push_req & ~push sets overflow; the data is dropped and the pointers are unchanged.
  - If the set and ovf_clr coincide, the set wins.
- Write: on push, mem[wr_ptr] ← {data_b, data_a}, sampled in the same cycle as push_req; wr_ptr increments and wraps modulo DEPTH.
- Read: instr_data = mem[rd_ptr], an asynchronous read of the registered pointer; rd_ptr increments on pop and wraps.
- Count: count_next = count + push − pop.
  - level = count.
  - instr_valid = (count ≠ 0), registered through count.
  - wrfull = (count == DEPTH).
  - almost_full = (count ≥ ALMOST_LVL).
  - All are registered state; no combinational path from wrreg or instr_ready.
- Latency: wrreg rises in cycle N → entry written at the end of N → instr_valid = 1 and wrfull updated in N+1.
- Empty: instr_ready while instr_valid = 0 has no effect.
- Push and pop on an empty FIFO: not possible, because pop requires instr_valid.
- Data stability: instr_data is stable while instr_valid = 1 and instr_ready = 0.

Optional Feature:
- Macro: INSTR_FIFO_STATS_EN.
- When defined, adds outputs stat_accepted[31:0] and stat_dropped[15:0].
  - stat_accepted increments on each push; stat_dropped increments on each drop.
  - Both wrap at maximum and clear on reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package instr_fifo_pkg holds:
  - the instr_t typedef (struct: payload[31:0], word_a[31:0]);
  - the strobe FSM enum {ST_IDLE, ST_HELD};
  - the default DEPTH constant.
- One sub-module, sync_fifo_mem: a DEPTH×64 register array with synchronous write and asynchronous read.
- Control (strobe FSM, pointers, count, flags) stays in instr_fifo_bridge.

Test Plan:
- Reset checks:
  - Assert reset_reset_n = 0 mid-traffic with level = 5 → all flags 0, level 0, instr_valid 0 immediately, without waiting for a clock edge.
  - After release, one push gives level 1.
- Single write with latency:
  - data_a = 0x0000_0012, data_b = 0xDEAD_BEEF, wrreg held high for 10 cycles, instr_ready = 0.
  - Expect exactly one entry, level = 1, instr_valid from cycle N+1, instr_data = 0xDEADBEEF_00000012.
- Fill and overflow:
  - 16 strobes with data_a = i.
  - Expect wrfull = 1 after the 16th, almost_full asserted once level reaches 14.
  - A 17th strobe sets overflow, level stays 16; stat_dropped = 1 when stats are enabled.
  - ovf_clr pulse → overflow = 0.
- Full with simultaneous push and pop:
  - FIFO full, instr_ready = 1 in the same cycle as push_req for data_a = 0xAA.
  - Expect entry 0 popped, 0xAA accepted at the tail, level stays 16, overflow stays 0.
- Ordering and wrap-around:
  - Interleave 40 strobes with random instr_ready.
  - Output sequence equals input order 0..39; no loss while level < 16; pointers wrap at least twice.
- Back-pressure stability:
  - instr_valid = 1, instr_ready = 0 for 20 cycles while 3 new strobes arrive.
  - instr_data is unchanged; level increments to 4.
